// File: rtl/ex_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_div
// Description : Iterative multiply/divide unit for the EX stage. It owns the
//               architectural HI/LO registers. MULT/MULTU use radix-2
//               shift-add and DIV/DIVU use restoring division, both on
//               32-bit magnitudes with a sign fixup in a final cycle. Every
//               operation takes 34 edges from the start edge to the point
//               where the unit is idle again.
// Ports       : clk       - pipeline clock (rising edge)
//               rst_n     - asynchronous active-low reset
//               start     - EX instruction is a mul/div (sampled in IDLE)
//               op        - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               DatoLec1  - rs operand (multiplicand / dividend)
//               DatoLec2  - rt operand (multiplier / divisor)
//               hi_we     - MTHI write enable (honoured in IDLE only)
//               lo_we     - MTLO write enable (honoured in IDLE only)
//               wdata     - MTHI/MTLO data
//               busy      - operation in flight (registered, state != IDLE)
//               done      - one-cycle pulse after HI/LO take a result
//               hi, lo    - HI/LO register contents
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] DatoLec1,
    input  logic [31:0] DatoLec2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] C_LAST_ITER = 6'd31;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_op_div;    // latched op[1]: 1 = divide, 0 = multiply
    logic [31:0] r_mag_a;     // |multiplicand| or |dividend|
    logic [31:0] r_mag_b;     // |multiplier| or |divisor|
    logic [31:0] r_raw_a;     // dividend as presented, for divide-by-zero
    logic        r_neg_res;   // operand signs differ
    logic        r_neg_a;     // dividend was negative (remainder sign)
    logic [63:0] r_acc;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic        w_load;
    logic        w_iter;
    logic        w_fix;
    logic        w_mt_ok;

    logic        w_signed;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    logic [4:0]  w_bit_idx;
    logic [63:0] w_addend;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_sub;
    logic        w_rem_ge;

    logic        w_div_zero;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_load  = 1'b0;
        w_iter  = 1'b0;
        w_fix   = 1'b0;
        w_mt_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load  = start;
                w_mt_ok = 1'b1;
            end
            S_CALC: begin
                w_iter = 1'b1;
            end
            S_FIX: begin
                w_fix = 1'b1;
            end
            default: begin
                w_mt_ok = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand conditioning: op[0] = 0 selects the signed variants.
    // Two's-complement negation of 0x8000_0000 yields 0x8000_0000, which is
    // the correct unsigned magnitude.
    // ------------------------------------------------------------------------
    assign w_signed = ~op[0];
    assign w_sign_a = w_signed & DatoLec1[31];
    assign w_sign_b = w_signed & DatoLec2[31];
    assign w_abs_a  = w_sign_a ? (~DatoLec1 + 32'd1) : DatoLec1;
    assign w_abs_b  = w_sign_b ? (~DatoLec2 + 32'd1) : DatoLec2;

    // ------------------------------------------------------------------------
    // Per-iteration arithmetic
    // ------------------------------------------------------------------------
    // Multiply consumes multiplier bits LSB-first (index = count); divide
    // consumes dividend bits MSB-first (index = 31 - count).
    assign w_bit_idx = ~r_cnt[4:0];

    assign w_addend  = r_mag_b[r_cnt[4:0]] ? ({32'd0, r_mag_a} << r_cnt[4:0])
                                           : 64'd0;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits without loss.
    assign w_rem_sh  = (r_rem << 1) | {32'd0, r_mag_a[w_bit_idx]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_rem_sub = w_rem_sh - {1'b0, r_mag_b};

    // ------------------------------------------------------------------------
    // Sign fixup applied on the FIX edge
    // ------------------------------------------------------------------------
    assign w_div_zero = (r_mag_b == 32'd0);
    assign w_prod_fix = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo_fix  = r_neg_res ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix  = r_neg_a ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 6'd0;
            r_op_div  <= 1'b0;
            r_mag_a   <= 32'd0;
            r_mag_b   <= 32'd0;
            r_raw_a   <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_acc     <= 64'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
        end else if (w_load) begin
            r_cnt     <= 6'd0;
            r_op_div  <= op[1];
            r_mag_a   <= w_abs_a;
            r_mag_b   <= w_abs_b;
            r_raw_a   <= DatoLec1;
            r_neg_res <= w_sign_a ^ w_sign_b;
            r_neg_a   <= w_sign_a;
            r_acc     <= 64'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
        end else if (w_iter) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_op_div) begin
                r_rem <= w_rem_ge ? w_rem_sub : w_rem_sh;
                r_quo <= {r_quo[30:0], w_rem_ge};
            end else begin
                r_acc <= r_acc + w_addend;
            end
        end
    end

    // ------------------------------------------------------------------------
    // HI/LO registers: results land on FIX; MTHI/MTLO only while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_fix) begin
            if (!r_op_div) begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
            end else if (w_div_zero) begin
                r_hi <= r_raw_a;
                r_lo <= 32'hFFFF_FFFF;
            end else begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else if (w_mt_ok) begin
            if (hi_we) begin
                r_hi <= wdata;
            end
            if (lo_we) begin
                r_lo <= wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status flags, registered from the next-state decode
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_fix;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mul_div
// Description : Directed self-checking bench for ex_mul_div. Each vector has
//               a hand-computed HI/LO result; latency, busy window, done
//               pulse count, MT* gating and asynchronous reset are checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mul_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] DatoLec1;
    logic [31:0] DatoLec2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    ex_mul_div u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .DatoLec1 (DatoLec1),
        .DatoLec2 (DatoLec2),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation and watch 40 edges after the start edge T0.
    // mt_at / st_at inject an MTHI (0x1234) or a stray start before that edge.
    // mt0 issues MTHI 0x99 on the start edge itself.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int mt_at, input int st_at, input logic mt0,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int busy_bad;
        int done_cnt;
        @(negedge clk);
        op       = o;
        DatoLec1 = a;
        DatoLec2 = b;
        start    = 1'b1;
        if (mt0) begin
            hi_we = 1'b1;
            wdata = 32'h99;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        check({tag, "_busy_t0"}, {31'd0, busy}, 32'd1);
        if (mt0) begin
            check({tag, "_mt_with_start"}, hi, 32'h99);
        end
        lat      = -1;
        busy_bad = 0;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == mt_at) begin
                hi_we = 1'b1;
                wdata = 32'h1234;
            end
            if (k == st_at) begin
                start    = 1'b1;
                op       = 2'b01;
                DatoLec1 = 32'd2;
                DatoLec2 = 32'd3;
            end
            @(posedge clk);
            #1;
            hi_we = 1'b0;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (busy !== (k < 33)) busy_bad++;
        end
        check({tag, "_latency"},  32'(lat),      32'd33);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_win"}, 32'(busy_bad), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int dcnt;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        DatoLec1 = 32'd0;
        DatoLec2 = 32'd0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi",   hi,             32'd0);
        check("rst_lo",   lo,             32'd0);
        check("rst_busy", {31'd0, busy},  32'd0);
        check("rst_done", {31'd0, done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MTHI/MTLO in IDLE, so the following reset has something to clear
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h55AA;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_idle_hi", hi, 32'h55AA);
        check("mt_idle_lo", lo, 32'h55AA);

        // Reset mid-operation: MULTU 5 x 7, reset after T10
        @(negedge clk);
        op       = 2'b01;
        DatoLec1 = 32'd5;
        DatoLec2 = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_hi",   hi,            32'd0);
        check("midrst_lo",   lo,            32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        check("midrst_idle",    {31'd0, busy}, 32'd0);

        // Arithmetic vectors
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b0,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, -1, -1, 1'b0,
               32'd100, 32'hFFFF_FFFF);
        run_op("div_m5_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, -1, -1, 1'b0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0,
               32'd0, 32'h8000_0000);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h10, -1, -1, 1'b0,
               32'h0000_000F, 32'h0FFF_FFFF);

        // MTHI at T5 and start at T20 while busy are both ignored
        run_op("div_busy", 2'b10, 32'd1000, 32'd7, 5, 20, 1'b0,
               32'd6, 32'd142);

        // MTLO in IDLE afterwards
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hABCD;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_hi", hi, 32'd6);

        // MTHI on the start edge lands, then the result overwrites it
        run_op("multu_mt0", 2'b01, 32'd3, 32'd4, -1, -1, 1'b1,
               32'd0, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
